// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> HOLD, with DROP
// absorbing the response to a request that a redirect has made stale.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets
// instead of silently aligning them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic [1:0]  jump,
  input  logic [31:0] jump_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_instr_nxt, if_pc_nxt;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        take_target;
  logic        accept;

  assign redirect   = (jump != 2'b00) | branch_sel;
  assign target_raw = (jump != 2'b00) ? jump_target : branch_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  assign misaligned  = redirect & (target_raw[1:0] != 2'b00);
  assign target      = target_raw;
  assign take_target = redirect & ~misaligned;

  // One-cycle trap pulse for a misaligned redirect.
  always_ff @(posedge clk) begin
    if (rst) misalign_trap <= 1'b0;
    else     misalign_trap <= misaligned;
  end
`else
  assign target        = target_raw & ~32'h0000_0003;
  assign take_target   = redirect;
  assign misalign_trap = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ) & ~rst;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // Next-state and datapath updates; a redirect overrides the normal pc flow.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_valid_nxt = if_valid;
    if_instr_nxt = if_instr;
    if_pc_nxt    = if_pc;
    case (state)
      S_REQ: begin
        if (redirect)    state_nxt = accept ? S_DROP : S_REQ;
        else if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          if_instr_nxt = imem_rsp_data;
          if_pc_nxt    = pc;
          if_valid_nxt = 1'b1;
          pc_nxt       = pc + 32'd4;
          state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || id_ready) begin
          if_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (take_target) pc_nxt = target;
  end

  // PC and decode-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      pc       <= pc_nxt;
      if_valid <= if_valid_nxt;
      if_instr <= if_instr_nxt;
      if_pc    <= if_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table walking the main fetch flow
// and redirect cases, then hand sequences for multi-cycle corner cases.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch_sel;
  logic [31:0] branch_target;
  logic [1:0]  jump;
  logic [31:0] jump_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        misalign_trap;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_sel     (branch_sel),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .misalign_trap  (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic [1:0]  jump;
    logic [31:0] jt;
    logic        bs;
    logic [31:0] bt;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic        e_trap;
  } vec_t;

  localparam int unsigned NVEC = 30;
  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h2222_0004;
  localparam logic [31:0] A2 = 32'h3333_0008;
  localparam logic [31:0] A3 = 32'h4444_FFFC;
  localparam logic [31:0] A4 = 32'h5555_0500;
  localparam logic [31:0] A5 = 32'h6666_0000;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;
  localparam logic [31:0] WRAP  = 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_ADDR = 32'h0000_0000;
  localparam logic        MIS_TRAP = 1'b1;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
  localparam logic        MIS_TRAP = 1'b0;
`endif

  vec_t vecs [NVEC];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(
    input logic rst_i, input logic rdy, input logic rv, input logic [31:0] rdata,
    input logic idr, input logic [1:0] jmp, input logic [31:0] jt,
    input logic bs, input logic [31:0] bt,
    input logic e_reqv, input logic [31:0] e_addr, input logic e_ifv,
    input logic [31:0] e_instr, input logic [31:0] e_ifpc, input logic e_trap);
    vec_t v;
    v.rst = rst_i; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr;
    v.jump = jmp; v.jt = jt; v.bs = bs; v.bt = bt;
    v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_ifv = e_ifv;
    v.e_instr = e_instr; v.e_ifpc = e_ifpc; v.e_trap = e_trap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    jump           = 2'b00;
    jump_target    = '0;
    branch_sel     = 1'b0;
    branch_target  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic reqv, input logic [31:0] addr,
                         input logic ifv, input logic [31:0] instr,
                         input logic [31:0] ipc, input logic trap);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, reqv});
    chk({tag, ".addr"},      imem_addr, addr);
    chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, ifv});
    chk({tag, ".if_instr"},  if_instr, instr);
    chk({tag, ".if_pc"},     if_pc, ipc);
    chk({tag, ".trap"},      {31'd0, misalign_trap}, {31'd0, trap});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;

    //             rst rdy rv rdata  idr jmp    jt            bs bt            reqv addr          ifv instr ifpc  trap
    vecs[0]  = mk(1, 0, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'h0,        0, '0,   '0,   0);
    vecs[1]  = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'h0,        0, '0,   '0,   0);
    vecs[2]  = mk(0, 1, 1, A0,    0, 2'b00, '0,           0, '0,           0, 32'h0,        0, '0,   '0,   0);
    vecs[3]  = mk(0, 0, 0, '0,    1, 2'b00, '0,           0, '0,           0, 32'h4,        1, A0,   32'h0, 0);
    vecs[4]  = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'h4,        0, A0,   32'h0, 0);
    vecs[5]  = mk(0, 0, 1, A1,    0, 2'b00, '0,           0, '0,           0, 32'h4,        0, A0,   32'h0, 0);
    vecs[6]  = mk(0, 0, 0, '0,    1, 2'b00, '0,           0, '0,           0, 32'h8,        1, A1,   32'h4, 0);
    vecs[7]  = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'h8,        0, A1,   32'h4, 0);
    vecs[8]  = mk(0, 0, 1, A2,    0, 2'b00, '0,           0, '0,           0, 32'h8,        0, A1,   32'h4, 0);
    // decode stalls for five cycles: nothing moves, no request
    vecs[9]  = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[10] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[11] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[12] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[13] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[14] = mk(0, 0, 0, '0,    1, 2'b00, '0,           0, '0,           0, 32'hC,        1, A2,   32'h8, 0);
    vecs[15] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'hC,        0, A2,   32'h8, 0);
    vecs[16] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'hC,        0, A2,   32'h8, 0);
    // JALR redirect while waiting; stale response two cycles later
    vecs[17] = mk(0, 0, 0, '0,    0, 2'b01, 32'h100,      0, '0,           0, 32'hC,        0, A2,   32'h8, 0);
    vecs[18] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           0, 32'h100,      0, A2,   32'h8, 0);
    vecs[19] = mk(0, 0, 1, STALE, 0, 2'b00, '0,           0, '0,           0, 32'h100,      0, A2,   32'h8, 0);
    vecs[20] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'h100,      0, A2,   32'h8, 0);
    // JAL beats a simultaneous branch
    vecs[21] = mk(0, 0, 0, '0,    0, 2'b10, 32'h200,      1, 32'h300,      1, 32'h100,      0, A2,   32'h8, 0);
    vecs[22] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           1, 32'h200,      0, A2,   32'h8, 0);
    // fetch at the top of the address space wraps to zero
    vecs[23] = mk(0, 0, 0, '0,    0, 2'b10, WRAP,         0, '0,           1, 32'h200,      0, A2,   32'h8, 0);
    vecs[24] = mk(0, 1, 0, '0,    0, 2'b00, '0,           0, '0,           1, WRAP,         0, A2,   32'h8, 0);
    vecs[25] = mk(0, 0, 1, A3,    0, 2'b00, '0,           0, '0,           0, WRAP,         0, A2,   32'h8, 0);
    vecs[26] = mk(0, 0, 0, '0,    1, 2'b00, '0,           0, '0,           0, 32'h0,        1, A3,   WRAP,  0);
    // misaligned redirect to 0x102
    vecs[27] = mk(0, 0, 0, '0,    0, 2'b01, 32'h102,      0, '0,           1, 32'h0,        0, A3,   WRAP,  0);
    vecs[28] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           1, MIS_ADDR,     0, A3,   WRAP,  MIS_TRAP);
    vecs[29] = mk(0, 0, 0, '0,    0, 2'b00, '0,           0, '0,           1, MIS_ADDR,     0, A3,   WRAP,  0);

    idle();
    rst = 1'b1;
    cyc();
    cyc();

    for (int i = 0; i < NVEC; i++) begin
      rst            = vecs[i].rst;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rdata;
      id_ready       = vecs[i].idr;
      jump           = vecs[i].jump;
      jump_target    = vecs[i].jt;
      branch_sel     = vecs[i].bs;
      branch_target  = vecs[i].bt;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_reqv, vecs[i].e_addr, vecs[i].e_ifv,
              vecs[i].e_instr, vecs[i].e_ifpc, vecs[i].e_trap);
      cyc();
    end

    // Redirect in REQ with the request accepted the same cycle -> DROP.
    idle();
    imem_req_ready = 1'b1; jump = 2'b10; jump_target = 32'h400;
    cyc(); idle();
    chk("drop.req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("drop.addr", imem_addr, 32'h400);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0001;
    cyc(); idle();
    chk("drop_exit.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_exit.if_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_exit.if_instr", if_instr, A3);

    // Redirect in WAIT with the response in the same cycle -> REQ, data discarded.
    imem_req_ready = 1'b1;
    cyc(); idle();
    chk("wait.req_valid", {31'd0, imem_req_valid}, 32'd0);
    jump = 2'b10; jump_target = 32'h500;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0002;
    cyc(); idle();
    chk("wait_rsp_redir.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("wait_rsp_redir.addr", imem_addr, 32'h500);
    chk("wait_rsp_redir.if_instr", if_instr, A3);
    chk("wait_rsp_redir.if_valid", {31'd0, if_valid}, 32'd0);

    // Branch in HOLD with id_ready high: entry dropped, pc redirected.
    imem_req_ready = 1'b1;
    cyc(); idle();
    imem_rsp_valid = 1'b1; imem_rsp_data = A4;
    cyc(); idle();
    chk("hold.if_valid", {31'd0, if_valid}, 32'd1);
    chk("hold.if_instr", if_instr, A4);
    chk("hold.if_pc", if_pc, 32'h500);
    chk("hold.addr", imem_addr, 32'h504);
    id_ready = 1'b1; branch_sel = 1'b1; branch_target = 32'h600;
    cyc(); idle();
    chk("hold_redir.if_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_redir.addr", imem_addr, 32'h600);
    chk("hold_redir.req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Reset while a request is outstanding; the late response is ignored.
    imem_req_ready = 1'b1;
    cyc(); idle();
    rst = 1'b1;
    cyc();
    chk_all("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst.addr", imem_addr, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0003;
    cyc(); idle();
    chk("late_rsp.req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("late_rsp.if_valid", {31'd0, if_valid}, 32'd0);
    chk("late_rsp.if_instr", if_instr, 32'h0);
    imem_req_ready = 1'b1;
    cyc(); idle();
    imem_rsp_valid = 1'b1; imem_rsp_data = A5;
    cyc(); idle();
    chk("refetch.if_valid", {31'd0, if_valid}, 32'd1);
    chk("refetch.if_instr", if_instr, A5);
    chk("refetch.if_pc", if_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 branch_sel  input  1  SHALL be the taken-branch indication from execute.
REQ-005 branch_target  input  32  SHALL be the branch destination from execute.
REQ-006 jump  input  2  SHALL be the jump type from execute: 01=JALR, 10=JAL, 00=none.
REQ-007 jump_target  input  32  SHALL be the jump destination from execute.
REQ-008 imem_req_valid  output  1  SHALL be the instruction-memory request valid.
REQ-009 imem_req_ready  input  1  SHALL be the request accept; the handshake completes when valid&ready.
REQ-010 imem_addr  output  32  SHALL be the request address, equal to the current PC.
REQ-011 imem_rsp_valid  input  1  SHALL be a one-cycle response strobe, at most one per accepted request.
REQ-012 imem_rsp_data  input  32  SHALL be the instruction word, valid with imem_rsp_valid.
REQ-013 if_valid / if_instr / if_pc  output  1/32/32  SHALL be the instruction, its PC and the valid flag presented to decode.
REQ-014 id_ready  input  1  SHALL indicate that decode consumes the entry when if_valid&id_ready.
REQ-015 misalign_trap  output  1  SHALL be the misaligned-redirect pulse.

Function
REQ-016 States SHALL be REQ, WAIT, HOLD and DROP, with at most one request outstanding.
REQ-017 REQ: imem_req_valid=1 and imem_addr=pc; valid&ready -> WAIT; otherwise stay in REQ, and imem_addr may change before acceptance.
REQ-018 WAIT: on imem_rsp_valid, if_instr<=rsp_data, if_pc<=pc, pc<=pc+4 (mod 2^32), if_valid<=1 and state -> HOLD.
REQ-019 HOLD: imem_req_valid=0 and if_valid/if_instr/if_pc held stable; on id_ready -> REQ with if_valid<=0.
REQ-020 Minimum latency SHALL be: request accepted at cycle N, response at N+k, if_valid high at N+k+1.
REQ-021 redirect = (jump!=0) | branch_sel; target = jump_target if jump!=0, else branch_target (jump has priority).
REQ-022 On redirect, pc<=target and if_valid<=0 next cycle; a held instruction SHALL be dropped even if id_ready is high in the same cycle.
REQ-023 Redirect in REQ with the request accepted in the same cycle SHALL go to DROP; if not accepted, stay in REQ with the new pc.
REQ-024 Redirect in WAIT SHALL go to DROP; if imem_rsp_valid is high in the same cycle, the response SHALL be discarded and the state goes to REQ.
REQ-025 Redirect in HOLD SHALL go to REQ.
REQ-026 DROP: imem_req_valid=0; on imem_rsp_valid, discard the data and go to REQ; a redirect in DROP SHALL update pc and remain in DROP.
REQ-027 Stale responses SHALL never reach if_instr.

Reset
REQ-028 While rst=1: pc=RESET_PC, state=REQ, imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, misalign_trap=0.
REQ-029 In the first cycle after rst deasserts, imem_req_valid=1 and imem_addr=RESET_PC.
REQ-030 rst mid-operation SHALL abandon any outstanding request; a later response SHALL be ignored because the block is in REQ and has no outstanding request.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect whose target[1:0]!=00 SHALL pulse misalign_trap for one cycle, leave pc unchanged, and follow the same state transitions as REQ-023 to REQ-025.
REQ-032 Macro undefined: target[1:0] SHALL be forced to 00 and misalign_trap tied to 0.

Verification
REQ-033 Reset, then ready=1 and responses 1 cycle later -> addrs 0,4,8 fetched and if_pc sequence 0,4,8 with matching instr.
REQ-034 id_ready=0 for 5 cycles during HOLD -> if_instr/if_pc stable and no new imem request.
REQ-035 Redirect with jump=01, jump_target=0x100 in WAIT; stale response 0xDEADBEEF arrives 2 cycles later -> discarded, next request addr=0x100.
REQ-036 Same cycle jump=10 (target 0x200) and branch_sel=1 (target 0x300) -> next request addr=0x200.
REQ-037 pc=0xFFFF_FFFC fetch -> next request addr=0x0000_0000.
REQ-038 Redirect to 0x102: with FETCH_MISALIGN_TRAP_EN -> one-cycle misalign_trap and pc unchanged; without it -> next request addr=0x100 and misalign_trap=0.
